// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel encoder.
//   - symbol constants: control-period codes, video guard-band codes,
//     and the symbol driven while in reset
//   - tally_t: signed running-disparity type
//   - slot_e: what kind of symbol the s2 slot turns into this cycle
//   - stage_t: one pipeline slot {ve, control, data}
//   - popcount8: ones count of a byte
package tmds_pkg;

  typedef logic signed [4:0] tally_t;

  typedef enum logic [1:0] {
    SLOT_CONTROL = 2'd0,
    SLOT_GUARD   = 2'd1,
    SLOT_VIDEO   = 2'd2
  } slot_e;

  typedef struct packed {
    logic       ve;
    logic [1:0] ctrl;
    logic [7:0] data;
  } stage_t;

  // Indexed by {C1,C0}.
  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam logic [9:0] VGB_CODE_CH02 = 10'b1011001100;
  localparam logic [9:0] VGB_CODE_CH1  = 10'b0100110011;
  localparam logic [9:0] RST_SYMBOL    = 10'b1101010100;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder_tm_choice.sv
// Transition-minimisation stage of the TMDS encoder.
//   d_i   [7:0] pixel byte
//   q_m_o [8:0] transition-minimised word; q_m_o[8]=1 means XOR chain,
//               q_m_o[8]=0 means XNOR chain
// Purely combinational.
module tm_choice
  import tmds_pkg::*;
(
  input  logic [7:0] d_i,
  output logic [8:0] q_m_o
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [7:0] q;

  always_comb begin
    n1       = popcount8(d_i);
    // XNOR chain wins for ones-heavy bytes; the tie at four ones is broken by d[0].
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d_i[0] == 1'b0));
    q        = '0;
    q[0]     = d_i[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d_i[i]) : (q[i-1] ^ d_i[i]);
    end
    q_m_o = {~use_xnor, q};
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS encoder: video data with running-disparity control,
// control-period codes and (optionally) the 2-symbol video leading guard band.
//   clk_in          pixel clock
//   rst_in          synchronous, active-high reset
//   data_in  [7:0]  pixel byte, used while ve_in=1
//   control_in [1:0] {C1,C0}, used while ve_in=0
//   ve_in           video data enable
//   tmds_out [9:0]  encoded symbol, registered, 3 cycles after its input
// Parameters:
//   CHANNEL   0/1/2 (blue/green/red); selects the guard-band code
//   GUARD_EN  1 = emit guard band before each video run
module tmds_channel_encoder #(
  parameter int CHANNEL  = 0,
  parameter bit GUARD_EN = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);
  import tmds_pkg::*;

  stage_t     s1_q, s1_d, s2_q, s2_d;
  tally_t     tally_q, tally_d;
  logic [9:0] tmds_d;
  // Counts the two slots after reset that still hold reset content; those
  // are forced to control-00 so a guard band cannot appear there.
  logic [1:0] flush_q, flush_d;
  slot_e      slot;

  logic [8:0] q_m;
  tally_t     n1_s, n0_s, diff, q8_x2, nq8_x2;
  logic       balanced, invert;

  tm_choice u_tm_choice (
    .d_i   (s2_q.data),
    .q_m_o (q_m)
  );

  // Pipeline advance and slot classification.
  always_comb begin
    s1_d    = '{ve: ve_in, ctrl: control_in, data: data_in};
    s2_d    = s1_q;
    flush_d = (flush_q != 2'd0) ? flush_q - 2'd1 : 2'd0;
    if (flush_q != 2'd0) begin
      slot = SLOT_CONTROL;
    end else if (s2_q.ve) begin
      slot = SLOT_VIDEO;
    end else if (GUARD_EN && (s1_q.ve || ve_in)) begin
      // Video reaches s2 within the next two cycles.
      slot = SLOT_GUARD;
    end else begin
      slot = SLOT_CONTROL;
    end
  end

  // Disparity arithmetic, all in signed 5-bit.
  always_comb begin
    n1_s     = $signed({1'b0, popcount8(q_m[7:0])});
    n0_s     = 5'sd8 - n1_s;
    diff     = n1_s - n0_s;
    q8_x2    = q_m[8] ? 5'sd2 : 5'sd0;
    nq8_x2   = q_m[8] ? 5'sd0 : 5'sd2;
    balanced = (tally_q == 5'sd0) || (n1_s == n0_s);
    // Invert when the word would push the tally further from zero.
    invert   = ((tally_q > 5'sd0) && (n1_s > n0_s)) ||
               ((tally_q < 5'sd0) && (n0_s > n1_s));
  end

  always_comb begin
    tmds_d  = CTRL_CODE[s2_q.ctrl];
    tally_d = '0;
    case (slot)
      SLOT_GUARD: begin
        tmds_d = (CHANNEL == 1) ? VGB_CODE_CH1 : VGB_CODE_CH02;
      end
      SLOT_VIDEO: begin
        if (balanced) begin
          tmds_d  = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
          tally_d = tally_q + (q_m[8] ? diff : -diff);
        end else if (invert) begin
          tmds_d  = {1'b1, q_m[8], ~q_m[7:0]};
          tally_d = tally_q + q8_x2 - diff;
        end else begin
          tmds_d  = {1'b0, q_m[8], q_m[7:0]};
          tally_d = tally_q + diff - nq8_x2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q     <= '0;
      s2_q     <= '0;
      tally_q  <= '0;
      flush_q  <= 2'd2;
      tmds_out <= RST_SYMBOL;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      tally_q  <= tally_d;
      flush_q  <= flush_d;
      tmds_out <= tmds_d;
    end
  end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder. Four instances share one stimulus stream:
//   a: CHANNEL 0, guard on   b: CHANNEL 1, guard on
//   c: CHANNEL 0, guard off  d: CHANNEL 2, guard on
module tb_tmds_channel_encoder;

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] C10  = 10'b0101010100;
  localparam logic [9:0] C11  = 10'b1010101011;
  localparam logic [9:0] G02  = 10'b1011001100;
  localparam logic [9:0] G1   = 10'b0100110011;
  localparam logic [9:0] VFF0 = 10'b1000000000;
  localparam logic [9:0] VFFN = 10'b0011111111;
  localparam logic [9:0] V00A = 10'b0100000000;
  localparam logic [9:0] V00B = 10'b1111111111;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ve = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] data = 8'h00;
  logic [9:0] tmds [4];
  logic signed [4:0] dut_tal [4];

  always #5 clk = ~clk;

  tmds_channel_encoder #(.CHANNEL(0), .GUARD_EN(1'b1)) dut_a (
    .clk_in(clk), .rst_in(rst), .data_in(data), .control_in(ctrl), .ve_in(ve), .tmds_out(tmds[0]));
  tmds_channel_encoder #(.CHANNEL(1), .GUARD_EN(1'b1)) dut_b (
    .clk_in(clk), .rst_in(rst), .data_in(data), .control_in(ctrl), .ve_in(ve), .tmds_out(tmds[1]));
  tmds_channel_encoder #(.CHANNEL(0), .GUARD_EN(1'b0)) dut_c (
    .clk_in(clk), .rst_in(rst), .data_in(data), .control_in(ctrl), .ve_in(ve), .tmds_out(tmds[2]));
  tmds_channel_encoder #(.CHANNEL(2), .GUARD_EN(1'b1)) dut_d (
    .clk_in(clk), .rst_in(rst), .data_in(data), .control_in(ctrl), .ve_in(ve), .tmds_out(tmds[3]));

  assign dut_tal[0] = dut_a.tally_q;
  assign dut_tal[1] = dut_b.tally_q;
  assign dut_tal[2] = dut_c.tally_q;
  assign dut_tal[3] = dut_d.tally_q;

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       rst;
    logic       ve;
    logic [1:0] ctrl;
    logic [7:0] data;
  } in_t;

  typedef struct packed {
    logic             vid;
    logic [7:0]       data;
    logic [3:0][4:0]  tal;
    logic [3:0][9:0]  sym;
  } exp_t;

  exp_t exp_q[$];
  in_t  h0 = '{rst: 1'b1, ve: 1'b0, ctrl: 2'b00, data: 8'h00};
  in_t  h1 = '{rst: 1'b1, ve: 1'b0, ctrl: 2'b00, data: 8'h00};
  in_t  h2 = '{rst: 1'b1, ve: 1'b0, ctrl: 2'b00, data: 8'h00};
  int   m_tal [4] = '{0, 0, 0, 0};
  int   cfg_ch [4] = '{0, 1, 0, 2};
  bit   cfg_ge [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  function automatic logic [8:0] qm_ref(input logic [7:0] d);
    int ones;
    logic x;
    logic [8:0] q;
    ones = $countones(d);
    x = (ones > 4) || (ones == 4 && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !x;
    return q;
  endfunction

  function automatic void vid_ref(input logic [7:0] d, input int t_in,
                                  output logic [9:0] s, output int t_out);
    logic [8:0] qm;
    int disp;
    qm = qm_ref(d);
    disp = 2 * $countones(qm[7:0]) - 8;
    t_out = t_in;
    if (t_in == 0 || disp == 0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      t_out = t_in + (qm[8] ? disp : -disp);
    end else if ((t_in > 0 && disp > 0) || (t_in < 0 && disp < 0)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      t_out = t_in + (qm[8] ? 2 : 0) - disp;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      t_out = t_in + disp - (qm[8] ? 0 : 2);
    end
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w;
    logic [7:0] o;
    w = s[9] ? ~s[7:0] : s[7:0];
    o = '0;
    o[0] = w[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return o;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_sym(input string nm, input int idx, input logic [9:0] got, input logic [9:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s dut%0d: got %b expected %b", nm, idx, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int idx, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [9:0] ea, input logic [9:0] eb,
                         input logic [9:0] ec, input logic [9:0] ed, input int et);
    chk_sym(nm, 0, tmds[0], ea);
    chk_sym(nm, 1, tmds[1], eb);
    chk_sym(nm, 2, tmds[2], ec);
    chk_sym(nm, 3, tmds[3], ed);
    for (int k = 0; k < 4; k++) chk_int({nm, "_tally"}, k, dut_tal[k], et);
  endtask

  // ---------------- driver ----------------
  // At each falling edge: score the symbol from the last rising edge, then
  // drive the next input and push the symbol expected at the coming edge.
  task automatic drive(input logic r, input logic v, input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        chk_sym("sym", k, tmds[k], e.sym[k]);
        chk_int("tally", k, dut_tal[k], $signed(e.tal[k]));
        if (e.vid) chk_sym("decode", k, {2'b00, decode(tmds[k])}, {2'b00, e.data});
      end
      vec_cnt++;
      if (dut_tal[0] > 5'sd10 || dut_tal[0] < -5'sd10) begin
        err_cnt++;
        $display("FAIL tally_range dut0: got %0d expected within -10..10", dut_tal[0]);
      end
    end
    rst = r; ve = v; ctrl = c; data = d;
    h2 = h1; h1 = h0; h0 = '{rst: r, ve: v, ctrl: c, data: d};
    e = '0;
    e.vid  = !h0.rst && !h1.rst && !h2.rst && h2.ve;
    e.data = h2.data;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] s;
      int t;
      t = 0;
      if (h0.rst) s = C00;
      else if (h1.rst || h2.rst) s = C00;
      else if (h2.ve) vid_ref(h2.data, m_tal[k], s, t);
      else if (cfg_ge[k] && (h1.ve || h0.ve)) s = (cfg_ch[k] == 1) ? G1 : G02;
      else begin
        case (h2.ctrl)
          2'b00: s = C00;
          2'b01: s = C01;
          2'b10: s = C10;
          default: s = C11;
        endcase
      end
      m_tal[k] = t;
      e.sym[k] = s;
      e.tal[k] = t[4:0];
    end
    exp_q.push_back(e);
  endtask

  // ---------------- directed table ----------------
  // exp_* is the symbol visible while the row is being applied.
  typedef struct packed {
    logic              rst;
    logic              ve;
    logic [1:0]        ctrl;
    logic [7:0]        data;
    logic              chk;
    logic [9:0]        exp_a;
    logic [9:0]        exp_c;
    logic              chk_t;
    logic signed [4:0] exp_t;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c, input logic [7:0] d,
                              input logic ck, input logic [9:0] ea, input logic [9:0] ec,
                              input logic ct, input logic signed [4:0] et);
    vec_t x;
    x = '{rst: r, ve: v, ctrl: c, data: d, chk: ck, exp_a: ea, exp_c: ec, chk_t: ct, exp_t: et};
    return x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    err_cnt++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    logic       ve_r;
    logic [9:0] gcode_a, gcode_b, gcode_c;
    bit         gap_ve [10];

    tbl[0]  = mk(1, 1, 2'd0, 8'hFF, 0, C00,  C00,  0, 0);
    tbl[1]  = mk(1, 1, 2'd0, 8'hFF, 1, C00,  C00,  1, 0);
    tbl[2]  = mk(0, 1, 2'd0, 8'hFF, 1, C00,  C00,  1, 0);
    tbl[3]  = mk(0, 1, 2'd0, 8'hFF, 1, C00,  C00,  1, 0);
    tbl[4]  = mk(0, 1, 2'd0, 8'hFF, 1, C00,  C00,  1, 0);
    tbl[5]  = mk(0, 0, 2'd0, 8'h00, 1, VFF0, VFF0, 1, -8);
    tbl[6]  = mk(0, 0, 2'd1, 8'h00, 1, VFFN, VFFN, 1, -2);
    tbl[7]  = mk(0, 0, 2'd2, 8'h00, 1, VFFN, VFFN, 1, 4);
    tbl[8]  = mk(0, 0, 2'd3, 8'h00, 1, C00,  C00,  1, 0);
    tbl[9]  = mk(0, 0, 2'd0, 8'h00, 1, C01,  C01,  1, 0);
    tbl[10] = mk(0, 0, 2'd0, 8'h00, 1, C10,  C10,  1, 0);
    tbl[11] = mk(0, 1, 2'd0, 8'h00, 1, C11,  C11,  1, 0);
    tbl[12] = mk(0, 1, 2'd0, 8'h00, 1, G02,  C00,  1, 0);
    tbl[13] = mk(0, 1, 2'd0, 8'h00, 1, G02,  C00,  1, 0);
    tbl[14] = mk(0, 0, 2'd0, 8'h00, 1, V00A, V00A, 1, -8);
    tbl[15] = mk(0, 0, 2'd0, 8'h00, 1, V00B, V00B, 1, 2);
    tbl[16] = mk(0, 0, 2'd0, 8'h00, 1, V00A, V00A, 1, -6);
    tbl[17] = mk(0, 0, 2'd0, 8'h00, 1, C00,  C00,  1, 0);

    for (int v = 0; v < 18; v++) begin
      drive(tbl[v].rst, tbl[v].ve, tbl[v].ctrl, tbl[v].data);
      if (tbl[v].chk) begin
        chk_sym("tbl", 0, tmds[0], tbl[v].exp_a);
        chk_sym("tbl", 2, tmds[2], tbl[v].exp_c);
      end
      if (tbl[v].chk_t) chk_int("tbl_tally", 2, dut_tal[2], tbl[v].exp_t);
    end

    // Guard band: ten control-10 slots, then three video 0x00 slots.
    for (int s = 0; s < 16; s++) begin
      int inp;
      drive(1'b0, (s >= 10 && s <= 12), 2'b10, 8'h00);
      inp = s - 3;
      if (inp >= 1 && inp <= 7) chk_all("gb_ctrl", C10, C10, C10, C10, 0);
      else if (inp == 8 || inp == 9) chk_all("gb_guard", G02, G1, C10, G02, 0);
      else if (inp == 10) chk_all("gb_vid0", V00A, V00A, V00A, V00A, -8);
      else if (inp == 11) chk_all("gb_vid1", V00B, V00B, V00B, V00B, 2);
      else if (inp == 12) chk_all("gb_vid2", V00A, V00A, V00A, V00A, -6);
    end

    // One-cycle blanking gap inside video.
    gap_ve = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    gcode_a = G02; gcode_b = G1; gcode_c = C00;
    for (int g = 0; g < 10; g++) begin
      int inp;
      drive(1'b0, gap_ve[g], 2'b00, 8'h00);
      inp = g - 3;
      case (inp)
        0: chk_all("gap_v0", V00A, V00A, V00A, V00A, -8);
        1: chk_all("gap_v1", V00B, V00B, V00B, V00B, 2);
        2: chk_all("gap_v2", V00A, V00A, V00A, V00A, -6);
        3: chk_all("gap_slot", gcode_a, gcode_b, gcode_c, gcode_a, 0);
        4: chk_all("gap_v4", V00A, V00A, V00A, V00A, -8);
        5: chk_all("gap_v5", V00B, V00B, V00B, V00B, 2);
        6: chk_all("gap_end", C00, C00, C00, C00, 0);
        default: ;
      endcase
    end

    // Randomised traffic against the model.
    ve_r = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic r;
      if ($urandom_range(0, 7) == 0) ve_r = ~ve_r;
      r = ($urandom_range(0, 999) == 0);
      drive(r, ve_r, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
